// File: rtl/lsu_byte_access_pkg.sv
// Shared definitions for the load/store byte access controller:
// RV32I width codes, FSM state encoding and the request legality check.
package lsu_byte_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        READ   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Illegal width code or misaligned offset; such requests never reach memory.
    function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_byte_access_load_extract.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// according to the load width code.
module lsu_byte_access_load_extract
    import lsu_byte_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (off)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = 32'h0;
        case (funct3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_W:    data = word;
            F3_BU:   data = {24'h0, sel_byte};
            F3_HU:   data = {16'h0, sel_half};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_access.sv
// Load/store access controller for a 32-bit byte-addressable data memory
// built from four write-first banks with synchronous read.
module lsu_byte_access
    import lsu_byte_access_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_error,
    output logic [3:0]               mem_byte_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [31:0]              mem_din,
    input  logic [31:0]              mem_dout
);

    state_t state, next_state;

    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [3:0]  be_q;

    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic [1:0]  off;
    logic        req_err;
    logic        accept;
    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic [31:0] load_data;

    // Address bits above the memory size are intentionally dropped (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDRESS_WIDTH+2];

    assign word_addr = req_addr[ADDRESS_WIDTH+1:2];
    assign off       = req_addr[1:0];
    assign req_err   = access_error(req_we, req_funct3, off);
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        lane_be   = 4'b0000;
        lane_data = 32'h0;
        case (req_funct3)
            F3_B: begin
                lane_be   = 4'b0001 << off;
                lane_data = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                lane_be   = 4'b0011 << off;
                lane_data = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                lane_be   = 4'b1111;
                lane_data = req_wdata;
            end
            default: begin
                lane_be   = 4'b0000;
                lane_data = 32'h0;
            end
        endcase
    end

    lsu_byte_access_load_extract u_extract (
        .funct3 (funct3_q),
        .off    (off_q),
        .word   (mem_dout),
        .data   (load_data)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_err ? RESP : ACCESS;
            ACCESS:  next_state = we_q ? RESP : READ;
            READ:    next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from state so an asynchronous reset kills the write strobe at once.
    always_comb begin
        mem_byte_enable = 4'b0000;
        if (state == ACCESS && we_q) mem_byte_enable = be_q;
    end

    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off_q      <= 2'b00;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            mem_addr   <= '0;
            mem_din    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                off_q      <= off;
                funct3_q   <= req_funct3;
                we_q       <= req_we;
                resp_error <= req_err;
                resp_rdata <= 32'h0;
                if (!req_err) begin
                    mem_addr <= word_addr;
                    be_q     <= lane_be;
                    if (req_we) mem_din <= lane_data;
                end
            end
            if (state == READ) resp_rdata <= load_data;
        end
    end

endmodule

// File: tb/tb_lsu_byte_access.sv
// Directed self-checking bench for lsu_byte_access with a behavioural
// four-bank write-first synchronous-read memory.
module tb_lsu_byte_access;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic [3:0]    mem_byte_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16] = '{default: 32'h0};
    int          be_cnt = 0;
    logic [3:0]  last_be = 4'h0;
    logic [31:0] last_din = 32'h0;
    logic [AW-1:0] last_addr = '0;

    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          be_before;

    always #5 clk = ~clk;

    lsu_byte_access #(.ADDRESS_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_byte_enable (mem_byte_enable),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout)
    );

    // Write-first banks: a written byte appears on the read port in the same edge.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
                mem_dout[b*8 +: 8]      <= mem_din[b*8 +: 8];
            end else begin
                mem_dout[b*8 +: 8]      <= mem[mem_addr][b*8 +: 8];
            end
        end
        if (|mem_byte_enable) begin
            be_cnt    <= be_cnt + 1;
            last_be   <= mem_byte_enable;
            last_din  <= mem_din;
            last_addr <= mem_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issue one request, measure edges from accept to resp_valid, optionally
    // hold off the response, then complete the handshake.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold, input string tag);
        checkOutput({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_error;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, " held resp_valid"}, {31'h0, resp_valid}, 32'h1);
            checkOutput({tag, " held rdata"}, resp_rdata, rdata);
            checkOutput({tag, " held req_ready"}, {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput({tag, " resp_valid after handshake"}, {31'h0, resp_valid}, 32'h0);
    endtask

    task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_data, input string tag);
        applyStimulus(1'b0, f3, addr, 32'h0, 0, tag);
        checkOutput({tag, " latency"}, lat, 32'd3);
        checkOutput({tag, " rdata"}, rdata, exp_data);
        checkOutput({tag, " error"}, {31'h0, err}, 32'h0);
    endtask

    task automatic doStore(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_din, input logic [AW-1:0] exp_addr,
                           input string tag);
        be_before = be_cnt;
        applyStimulus(1'b1, f3, addr, wdata, 0, tag);
        checkOutput({tag, " latency"}, lat, 32'd2);
        checkOutput({tag, " rdata"}, rdata, 32'h0);
        checkOutput({tag, " error"}, {31'h0, err}, 32'h0);
        checkOutput({tag, " enable cycles"}, be_cnt - be_before, 32'd1);
        checkOutput({tag, " enable"}, {28'h0, last_be}, {28'h0, exp_be});
        checkOutput({tag, " din"}, last_din, exp_din);
        checkOutput({tag, " word addr"}, {28'h0, last_addr}, {28'h0, exp_addr});
    endtask

    task automatic doError(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input string tag);
        be_before = be_cnt;
        applyStimulus(we, f3, addr, 32'hFFFF_FFFF, 0, tag);
        checkOutput({tag, " latency"}, lat, 32'd1);
        checkOutput({tag, " error"}, {31'h0, err}, 32'h1);
        checkOutput({tag, " rdata"}, rdata, 32'h0);
        checkOutput({tag, " no enable"}, be_cnt - be_before, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("reset resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset resp_error", {31'h0, resp_error}, 32'h0);
        checkOutput("reset mem_byte_enable", {28'h0, mem_byte_enable}, 32'h0);
        checkOutput("reset mem_addr", {28'h0, mem_addr}, 32'h0);
        checkOutput("reset mem_din", mem_din, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        doStore(3'b010, 32'h04, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 4'd1, "SW 0x04");
        doStore(3'b000, 32'h07, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 4'd1, "SB 0x07");
        doLoad(3'b000, 32'h07, 32'hFFFF_FFA5, "LB 0x07");
        doLoad(3'b100, 32'h07, 32'h0000_00A5, "LBU 0x07");
        doStore(3'b001, 32'h0A, 32'h0000_8001, 4'b1100, 32'h8001_8001, 4'd2, "SH 0x0A");
        doLoad(3'b001, 32'h0A, 32'hFFFF_8001, "LH 0x0A");
        doLoad(3'b101, 32'h0A, 32'h0000_8001, "LHU 0x0A");

        doError(1'b0, 3'b010, 32'h06, "LW 0x06");
        doError(1'b1, 3'b001, 32'h03, "SH 0x03");
        doError(1'b0, 3'b011, 32'h00, "load f3 011");
        doError(1'b1, 3'b100, 32'h00, "store f3 100");
        doError(1'b0, 3'b101, 32'h01, "LHU 0x01");

        applyStimulus(1'b0, 3'b010, 32'h04, 32'h0, 5, "LW hold");
        checkOutput("LW hold latency", lat, 32'd3);
        checkOutput("LW hold rdata", rdata, 32'hA5AD_BEEF);

        doLoad(3'b010, 32'h44, 32'hA5AD_BEEF, "LW wrap 0x44");
        doStore(3'b010, 32'h08, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 4'd2, "SW 0x08");
        doLoad(3'b010, 32'h08, 32'h0BAD_F00D, "LW after SW");
        doLoad(3'b001, 32'h08, 32'hFFFF_F00D, "LH 0x08");
        doLoad(3'b000, 32'h09, 32'hFFFF_FFF0, "LB 0x09");
        doLoad(3'b101, 32'h08, 32'h0000_F00D, "LHU 0x08");

        // Reset in the middle of a store's ACCESS cycle.
        be_before  = be_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h00;
        req_wdata  = 32'h1122_3344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rst ACCESS enable before", {28'h0, mem_byte_enable}, 32'hF);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst ACCESS enable dropped", {28'h0, mem_byte_enable}, 32'h0);
        @(posedge clk); #1;
        checkOutput("rst req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("rst resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst resp_error", {31'h0, resp_error}, 32'h0);
        checkOutput("rst mem_addr", {28'h0, mem_addr}, 32'h0);
        checkOutput("rst mem_din", mem_din, 32'h0);
        checkOutput("rst no write", be_cnt - be_before, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        doLoad(3'b010, 32'h00, 32'h0000_0000, "LW 0x00 after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
